// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand-fetch stage and its forwarding resolver.
package operand_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned AW      = 5;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FRESH = 2'd1,
    ST_HELD  = 2'd2
  } opf_state_e;

  // One register-file write as seen on the writeback snoop.
  typedef struct packed {
    logic            en;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_snoop_t;

  function automatic logic [AW-1:0] rs1_of(input logic [ILEN-1:0] instr);
    return instr[RS1_LSB +: AW];
  endfunction

  function automatic logic [AW-1:0] rs2_of(input logic [ILEN-1:0] instr);
    return instr[RS2_LSB +: AW];
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Instruction in/out handshakes, register-file read port and writeback snoop of the operand-fetch stage.
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_instr;
  logic [AW-1:0]   rf_raddr1;
  logic [AW-1:0]   rf_raddr2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;

  modport master (
    input  in_valid, in_instr, rf_rdata1, rf_rdata2, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, rf_raddr1, rf_raddr2, out_valid, out_instr, out_rs1_data, out_rs2_data
  );

  modport slave (
    output in_valid, in_instr, rf_rdata1, rf_rdata2, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_instr, out_rs1_data, out_rs2_data
  );

endinterface

// File: rtl/operand_fetch_fwd_mux.sv
// Per-operand resolver: x0 forcing, optional writeback forwarding (OPFETCH_BYPASS_EN), then RF or hold data.
module opfetch_fwd_mux
  import operand_fetch_pkg::*;
(
  input  logic            fresh,
  input  logic [AW-1:0]   rs,
  input  logic [XLEN-1:0] rf_rdata,
  input  logic [XLEN-1:0] hold,
  input  wb_snoop_t       wb,
  input  wb_snoop_t       wb_q,
  output logic [XLEN-1:0] operand_c
);

  // Later assignments take priority: x0, then current write, then accept-edge write.
  always_comb begin
    operand_c = fresh ? rf_rdata : hold;
`ifdef OPFETCH_BYPASS_EN
    if (fresh && wb_q.en && (wb_q.addr == rs)) operand_c = wb_q.data;
    if (wb.en && (wb.addr == rs))              operand_c = wb.data;
`endif
    if (rs == '0) operand_c = '0;
  end

`ifndef OPFETCH_BYPASS_EN
  logic unused_snoop;
  assign unused_snoop = ^{wb, wb_q};
`endif

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: single slot between the register file and execute.
// Writeback forwarding is built only when OPFETCH_BYPASS_EN is defined.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic           CLK,
  input  logic           RST_N,
  operand_fetch_if.master bus
);

  opf_state_e      state;
  opf_state_e      state_d;
  logic [ILEN-1:0] instr_q;
  logic [XLEN-1:0] hold1_q;
  logic [XLEN-1:0] hold2_q;
  logic [XLEN-1:0] op1_c;
  logic [XLEN-1:0] op2_c;
  logic            fire_c;
  logic            in_ready_c;
  logic            accept_c;
  logic            fresh_c;
  wb_snoop_t       wb_c;
  wb_snoop_t       wb_q;

  assign fire_c     = (state != ST_EMPTY) & bus.out_ready;
  assign in_ready_c = (state == ST_EMPTY) | fire_c;
  assign accept_c   = bus.in_valid & in_ready_c;
  assign fresh_c    = (state == ST_FRESH);
  assign wb_c       = '{en: bus.wb_en, addr: bus.wb_addr, data: bus.wb_data};

  // The register file samples these on the accept edge.
  assign bus.rf_raddr1 = rs1_of(bus.in_instr);
  assign bus.rf_raddr2 = rs2_of(bus.in_instr);

  always_comb begin
    state_d = state;
    if (accept_c)                state_d = ST_FRESH;
    else if (fire_c)             state_d = ST_EMPTY;
    else if (state == ST_FRESH)  state_d = ST_HELD;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_EMPTY;
    else        state <= state_d;
  end

  // Hold registers track the resolved operands while the slot is stalled; RF data is stale after FRESH.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instr_q <= '0;
      hold1_q <= '0;
      hold2_q <= '0;
    end else begin
      if (accept_c) instr_q <= bus.in_instr;
      if ((state != ST_EMPTY) && !fire_c) begin
        hold1_q <= op1_c;
        hold2_q <= op2_c;
      end
    end
  end

`ifdef OPFETCH_BYPASS_EN
  // Remembers the write on the accept edge, which the RF read misses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) wb_q <= '0;
    else        wb_q <= wb_c;
  end
`else
  assign wb_q = '0;
`endif

  opfetch_fwd_mux u_fwd_rs1 (
    .fresh     (fresh_c),
    .rs        (rs1_of(instr_q)),
    .rf_rdata  (bus.rf_rdata1),
    .hold      (hold1_q),
    .wb        (wb_c),
    .wb_q      (wb_q),
    .operand_c (op1_c)
  );

  opfetch_fwd_mux u_fwd_rs2 (
    .fresh     (fresh_c),
    .rs        (rs2_of(instr_q)),
    .rf_rdata  (bus.rf_rdata2),
    .hold      (hold2_q),
    .wb        (wb_c),
    .wb_q      (wb_q),
    .operand_c (op2_c)
  );

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = (state != ST_EMPTY);
  assign bus.out_instr    = instr_q;
  assign bus.out_rs1_data = op1_c;
  assign bus.out_rs2_data = op2_c;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage that sits in front of the 32x32 register file and acts as its read-side initiator. It accepts one instruction per valid/ready handshake, drives the register file's two synchronous read addresses, and collects the read data that returns one cycle later. It corrects that data for writebacks the register file has not yet made visible, forces x0 to zero, and presents the instruction with both operands to the execute stage over a second valid/ready handshake.

## Interface
- XLEN, 32, data width; must equal the register-file width.
- AW, 5, register address width.
- CLK  in  1  sole clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  an instruction is offered.
- in_ready  out  1  the stage can accept the offered instruction.
- in_instr  in  32  RV32 instruction word; rs1=[19:15], rs2=[24:20].
- rf_raddr1  out  AW  drives the register file's ReadAddress1; equals in_instr[19:15].
- rf_raddr2  out  AW  drives the register file's ReadAddress2; equals in_instr[24:20].
- rf_rdata1  in  XLEN  the register file's ReadData1, registered inside the register file.
- rf_rdata2  in  XLEN  the register file's ReadData2, registered inside the register file.
- wb_en  in  1  snoop of the register file's WriteEn.
- wb_addr  in  AW  snoop of WriteAddress.
- wb_data  in  XLEN  snoop of WriteData.
- out_valid  out  1  the operand bundle is valid.
- out_ready  in  1  the consumer accepts the bundle.
- out_instr  out  32  the instruction carried with the bundle.
- out_rs1_data  out  XLEN  resolved rs1 operand.
- out_rs2_data  out  XLEN  resolved rs2 operand.

## Operation
- Single-slot pipeline with three states.
  - EMPTY: the slot holds nothing.
  - FRESH: the first cycle after accept; operands are taken from rf_rdata.
  - HELD: operands are taken from internal hold registers.
- Accept: happens when in_valid and in_ready are both high. The read addresses are combinational from in_instr, so the register file samples them on the same edge.
- in_ready = (state==EMPTY) | (out_valid & out_ready), which gives full throughput of one instruction per cycle.
- State transitions:
  - Accept moves the slot to FRESH, from any state.
  - FRESH or HELD with a fire (out_valid & out_ready) and no accept moves to EMPTY.
  - FRESH without a fire moves to HELD, and the resolved operands are captured into the hold registers.
  - HELD without a fire stays in HELD.
- out_valid = (state != EMPTY).
- Operand resolution, applied per operand in priority order:
  1. If rs==0, the operand is 0.
  2. If the current wb_en is high and wb_addr==rs, the operand is wb_data.
  3. In FRESH only: if the registered snoop (wb_en_q, wb_addr_q) matches rs, the operand is wb_data_q. This covers a write on the accept edge, which the register file returns stale.
  4. Otherwise the operand is rf_rdata in FRESH, or the hold register in HELD.
- In HELD, each hold register also loads wb_data on any edge where wb_en is high and wb_addr==rs with rs!=0.
- The register file's read data is never trusted after FRESH, because its read registers reload every cycle.
- Any rd field is ignored; the stage never writes the register file.

## Timing
- Reset values: state=EMPTY, out_valid=0, out_instr=0, out_rs1_data=0, out_rs2_data=0, hold registers=0, wb_en_q=0.
- Latency: out_valid rises exactly one cycle after the accept edge.
- Stability: while out_valid is high and out_ready is low, out_instr is stable. The operand outputs change only by forwarding of newer writebacks.
- Reset mid-operation: the held instruction is dropped and out_valid falls immediately, asynchronously.
- Simultaneous fire and accept: the new instruction enters FRESH and the old one retires, with no bubble.
- A write to x0 on wb is never forwarded.

## Configuration
- OPFETCH_BYPASS_EN defined: rules 2 and 3 of operand resolution and the HELD-state snoop are present.
- OPFETCH_BYPASS_EN undefined: operands are the raw rf_rdata in FRESH and the captured value in HELD, and the wb_* inputs are unused. An external hazard unit must stall conflicting instructions. The x0 forcing remains.

## Structure
- Shared package: XLEN, AW, rs1/rs2 bit-field positions, and the three-value state enum.
- One natural sub-module, opfetch_fwd_mux: a combinational per-operand resolver instantiated twice, one instance per operand.

## Test plan
- Reset preload: register file reg2=7, reg3=6; offer an instruction with rs1=2, rs2=3 and hold out_ready high. The next cycle shows out_valid=1, rs1=7, rs2=6.
- x0 read: offer rs1=0, rs2=0 with reg0 preloaded to 0xDEAD. Both operands are 0.
- Accept-edge write: wb writes reg5=0x55 on the same edge that rs1=5 is accepted. In the FRESH cycle rs1=0x55, not the old value.
- Stall with snoop: out_ready=0 for 3 cycles after accept, and reg3 is written 0x99 in the second stall cycle. The operand becomes 0x99, and out_instr is unchanged throughout.
- Back-to-back: 4 instructions offered on consecutive cycles with out_ready=1. out_valid is high for 4 consecutive cycles, in order, with no bubbles.
- Mid-flight reset: assert RST_N=0 while in HELD. out_valid=0 immediately; after release the state is EMPTY and in_ready=1.
